// File: rtl/csi_rgb888_packer.sv
// csi_rgb888_packer: raster pixels to CSI-2 token stream (FS/LS/DATA/LE/FE) through a FWFT output FIFO.
// Define CSI_PACK_SWAP_RB_EN to pack each pixel as R,G,B instead of the standard B,G,R.
module csi_rgb888_packer #(
  parameter int FIFO_AW = 4,
  parameter int LC_W    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  pix_r,
  input  logic [7:0]  pix_g,
  input  logic [7:0]  pix_b,
  input  logic        pix_de,
  input  logic        pix_vsync,
  output logic [2:0]  out_kind,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        ovf_err,
  output logic        frm_err
);
  localparam logic [2:0] K_DATA = 3'd0, K_FS = 3'd1, K_FE = 3'd2, K_LS = 3'd3, K_LE = 3'd4;
  localparam int DEPTH = 1 << FIFO_AW;
  typedef enum logic [2:0] {IDLE, FRAME, LINE, FLUSH, LEND, FEND} st_e;
  st_e st_q;
  logic [7:0] r_q, g_q, b_q;
  logic de_q, vs_q, de_p_q, vs_p_q;
  logic [23:0] px;
  logic [47:0] acc_q, acc_ins, acc_d;
  logic [2:0] cnt_q, cnt_ins, cnt_d;
  logic word_rdy, vs_rise, de_rise, in_gap, trunc_q;
  logic [15:0] fn_q, fn_d, ln_q, ln_d, bc;
  logic [LC_W-1:0] pc_q;
  logic tv_q;
  logic [2:0] tk_q;
  logic [31:0] td_q;
  logic [34:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wp_q, rp_q;
  logic [FIFO_AW:0] fc_q;
  logic rd, full, wr_ok;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
      de_q <= 1'b0;
      vs_q <= 1'b0;
      de_p_q <= 1'b0;
      vs_p_q <= 1'b0;
    end else begin
      r_q <= pix_r;
      g_q <= pix_g;
      b_q <= pix_b;
      de_q <= pix_de;
      vs_q <= pix_vsync;
      de_p_q <= de_q;
      vs_p_q <= vs_q;
    end
`ifdef CSI_PACK_SWAP_RB_EN
  assign px = {b_q, g_q, r_q};
`else
  assign px = {r_q, g_q, b_q};
`endif
  always_comb begin
    acc_ins = acc_q | ({24'd0, px} << {cnt_q, 3'b000});
    cnt_ins = cnt_q + 3'd3;
    word_rdy = cnt_ins >= 3'd4;
    acc_d = word_rdy ? {32'd0, acc_ins[47:32]} : acc_ins;
    cnt_d = word_rdy ? cnt_ins - 3'd4 : cnt_ins;
    fn_d = (fn_q == 16'hFFFF) ? 16'd1 : fn_q + 16'd1;
    ln_d = ln_q + 16'd1;
    bc = 16'(pc_q * 3);
    vs_rise = vs_q & ~vs_p_q;
    de_rise = de_q & ~de_p_q;
    in_gap = (st_q == FLUSH) | (st_q == LEND) | (st_q == FEND);
  end
  // trunc_q marks de still high from a line cut short by vsync; that tail is dropped silently
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q <= IDLE;
      fn_q <= '0;
      ln_q <= '0;
      pc_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      tv_q <= 1'b0;
      tk_q <= K_DATA;
      td_q <= '0;
      trunc_q <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      tv_q <= 1'b0;
      if (!de_q) trunc_q <= 1'b0;
      if (de_q && !trunc_q && in_gap) frm_err <= 1'b1;
      case (st_q)
        IDLE: if (vs_rise) begin
          tv_q <= 1'b1;
          tk_q <= K_FS;
          td_q <= {16'd0, fn_d};
          fn_q <= fn_d;
          ln_q <= '0;
          st_q <= FRAME;
        end
        FRAME: if (!vs_q) st_q <= FEND;
        else if (de_rise) begin
          tv_q <= 1'b1;
          tk_q <= K_LS;
          td_q <= {16'd0, ln_d};
          ln_q <= ln_d;
          acc_q <= acc_d;
          cnt_q <= cnt_d;
          pc_q <= pc_q + 1'b1;
          st_q <= LINE;
        end
        LINE: if (de_q && vs_q) begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
          pc_q <= pc_q + 1'b1;
          tv_q <= word_rdy;
          tk_q <= K_DATA;
          td_q <= acc_ins[31:0];
        end else begin
          trunc_q <= de_q;
          st_q <= FLUSH;
        end
        FLUSH: begin
          tv_q <= cnt_q != 3'd0;
          tk_q <= K_DATA;
          td_q <= acc_q[31:0];
          acc_q <= '0;
          cnt_q <= '0;
          st_q <= LEND;
        end
        LEND: begin
          tv_q <= 1'b1;
          tk_q <= K_LE;
          td_q <= {bc, 16'h0};
          pc_q <= '0;
          st_q <= vs_q ? FRAME : FEND;
        end
        FEND: begin
          tv_q <= 1'b1;
          tk_q <= K_FE;
          td_q <= {16'd0, fn_q};
          st_q <= IDLE;
        end
        default: st_q <= IDLE;
      endcase
    end
  assign out_valid = fc_q != '0;
  assign rd = out_valid & out_ready;
  assign full = fc_q == (FIFO_AW + 1)'(DEPTH);
  assign wr_ok = tv_q & (~full | rd);
  assign {out_kind, out_data} = out_valid ? mem[rp_q] : 35'd0;
  always_ff @(posedge clk)
    if (wr_ok) mem[wp_q] <= {tk_q, td_q};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      fc_q <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (wr_ok) wp_q <= wp_q + 1'b1;
      if (rd) rp_q <= rp_q + 1'b1;
      fc_q <= fc_q + (FIFO_AW + 1)'(wr_ok) - (FIFO_AW + 1)'(rd);
      if (tv_q && !wr_ok) ovf_err <= 1'b1;
    end
endmodule

// File: tb/tb_csi_rgb888_packer.sv
// tb_csi_rgb888_packer: directed token-sequence, backpressure, framing-error and reset checks.
module tb_csi_rgb888_packer;
  localparam logic [2:0] K_DATA = 3'd0, K_FS = 3'd1, K_FE = 3'd2, K_LS = 3'd3, K_LE = 3'd4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] pix_r = 8'h11, pix_g = 8'h22, pix_b = 8'h33;
  logic pix_de = 1'b0, pix_vsync = 1'b0, out_ready = 1'b1;
  logic [2:0] out_kind;
  logic [31:0] out_data;
  logic out_valid, ovf_err, frm_err;
  int n_chk = 0, n_fail = 0;
  logic [34:0] cap [$];
  logic [31:0] wv [3];

  csi_rgb888_packer dut (
    .clk(clk), .rst_n(rst_n), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_de(pix_de), .pix_vsync(pix_vsync), .out_kind(out_kind), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .ovf_err(ovf_err), .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (out_valid && out_ready) cap.push_back({out_kind, out_data});

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic de, input logic vs, input int n);
    pix_de = de;
    pix_vsync = vs;
    cyc(n);
  endtask

  task automatic line(input int n);
    drive(1'b1, 1'b1, n);
    drive(1'b0, 1'b1, 4);
  endtask

  task automatic expect_tok(input string tag, input logic [2:0] k, input logic [31:0] d);
    int t = 0;
    while (cap.size() == 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (cap.size() == 0) chk({tag, "_timeout"}, 64'(cap.size()), 64'd1);
    else chk(tag, 64'(cap.pop_front()), 64'({k, d}));
  endtask

  task automatic expect_line(input string tag, input int ln, input int nw, input logic [31:0] last, input logic [31:0] le);
    expect_tok($sformatf("%s_ls", tag), K_LS, 32'(ln));
    for (int i = 0; i < nw; i++) expect_tok($sformatf("%s_d%0d", tag, i), K_DATA, wv[i % 3]);
    if (last != 32'd0) expect_tok($sformatf("%s_flush", tag), K_DATA, last);
    expect_tok($sformatf("%s_le", tag), K_LE, le);
  endtask

  initial begin
    wv[0] = 32'h33112233;
    wv[1] = 32'h22331122;
    wv[2] = 32'h11223311;
    cyc(2);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_kind", 64'(out_kind), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_ovf", 64'(ovf_err), 64'd0);
    chk("rst_frm", 64'(frm_err), 64'd0);
    rst_n = 1'b1;
    cyc(2);
    // frame 1: 4 lines x 8 pixels
    drive(1'b0, 1'b1, 3);
    repeat (4) line(8);
    drive(1'b0, 1'b0, 6);
    expect_tok("f1_fs", K_FS, 32'd1);
    for (int l = 1; l <= 4; l++) expect_line($sformatf("f1_l%0d", l), l, 6, 32'd0, 32'h00180000);
    expect_tok("f1_fe", K_FE, 32'd1);
    chk("f1_ovf", 64'(ovf_err), 64'd0);
    chk("f1_frm", 64'(frm_err), 64'd0);
    // frame 2: 5-pixel line, then a 5-pixel line cut by vsync while de high
    drive(1'b0, 1'b1, 3);
    line(5);
    drive(1'b1, 1'b1, 5);
    drive(1'b1, 1'b0, 2);
    drive(1'b0, 1'b0, 6);
    expect_tok("f2_fs", K_FS, 32'd2);
    expect_line("f2_l1", 1, 3, 32'h00112233, 32'h000F0000);
    expect_line("f2_l2", 2, 3, 32'h00112233, 32'h000F0000);
    expect_tok("f2_fe", K_FE, 32'd2);
    chk("f2_frm", 64'(frm_err), 64'd0);
    // frame 3: 800-pixel line with consumer stalled, then de pulse during FEND
    out_ready = 1'b0;
    drive(1'b0, 1'b1, 3);
    line(800);
    cyc(30);
    chk("bp_valid", 64'(out_valid), 64'd1);
    chk("bp_head", 64'({out_kind, out_data}), 64'({K_FS, 32'd3}));
    chk("bp_ovf", 64'(ovf_err), 64'd1);
    cyc(20);
    chk("bp_hold", 64'({out_kind, out_data}), 64'({K_FS, 32'd3}));
    out_ready = 1'b1;
    expect_tok("bp_fs", K_FS, 32'd3);
    expect_tok("bp_ls", K_LS, 32'd1);
    for (int i = 0; i < 14; i++) expect_tok($sformatf("bp_d%0d", i), K_DATA, wv[i % 3]);
    cyc(10);
    chk("bp_drained", 64'(cap.size()), 64'd0);
    drive(1'b1, 1'b0, 3);
    drive(1'b0, 1'b0, 6);
    expect_tok("f3_fe", K_FE, 32'd3);
    chk("fend_frm", 64'(frm_err), 64'd1);
    chk("fend_no_pix", 64'(cap.size()), 64'd0);
    // frame 4: reset mid-line
    drive(1'b0, 1'b1, 3);
    expect_tok("f4_fs", K_FS, 32'd4);
    drive(1'b1, 1'b1, 3);
    rst_n = 1'b0;
    pix_de = 1'b0;
    pix_vsync = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_kind", 64'(out_kind), 64'd0);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    chk("mid_rst_ovf", 64'(ovf_err), 64'd0);
    chk("mid_rst_frm", 64'(frm_err), 64'd0);
    cyc(2);
    cap.delete();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 3);
    drive(1'b0, 1'b1, 3);
    line(2);
    drive(1'b0, 1'b0, 6);
    expect_tok("r_fs", K_FS, 32'd1);
    expect_line("r_l1", 1, 1, 32'h00001122, 32'h00060000);
    expect_tok("r_fe", K_FE, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
